// File: rtl/rx_sync_ctrl.sv
// rx_sync_ctrl: PSS search/confirm/track sequencer.
// Drives PSS_detector mode, locks N_id_2, gates CFO updates.
module rx_sync_ctrl #(
  parameter int SSB_PERIOD   = 76800,
  parameter int WIN          = 64,
  parameter int CONFIRM_HITS = 2,
  parameter int MAX_MISSES   = 3,
  localparam int CNT_DW = $clog2(2*SSB_PERIOD+1),
  localparam int MW =
    ($clog2(MAX_MISSES+1) < 2) ? 2 : $clog2(MAX_MISSES+1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          s_axis_in_tvalid,
  input  logic          N_id_2_valid_i,
  input  logic [1:0]    N_id_2_i,
  input  logic          N_id_valid_i,
  input  logic          CFO_valid_i,
  output logic [1:0]    PSS_detector_mode_o,
  output logic [1:0]    requested_N_id_2_o,
  output logic          CFO_valid_o,
  output logic          ssb_start_o,
  output logic          synced_o,
  output logic [1:0]    state_o,
  output logic [MW-1:0] miss_cnt_o
);

  localparam int HW =
    ($clog2(CONFIRM_HITS+1) < 1) ? 1 : $clog2(CONFIRM_HITS+1);

  localparam logic [CNT_DW-1:0] C_WLO  = CNT_DW'(SSB_PERIOD-WIN);
  localparam logic [CNT_DW-1:0] C_MISS = CNT_DW'(SSB_PERIOD+WIN);
  localparam logic [CNT_DW-1:0] C_TMO  = CNT_DW'(2*SSB_PERIOD);
  localparam logic [CNT_DW-1:0] C_WIN  = CNT_DW'(WIN);
  localparam logic [HW-1:0]     C_HITS = HW'(CONFIRM_HITS);
  localparam logic [MW-1:0]     C_MAXM = MW'(MAX_MISSES);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_CONFIRM = 2'd1,
    S_WAIT    = 2'd2,
    S_TRACK   = 2'd3
  } st_t;

  st_t               r_state, w_state_n;
  logic [CNT_DW-1:0] r_cnt, w_cnt_n;
  logic [HW-1:0]     r_hits, w_hits_n, w_hits_inc;
  logic [MW-1:0]     r_misses, w_misses_n, w_miss_inc;
  logic [1:0]        r_req, w_req_n;
  logic [1:0]        r_mode, w_mode_n;
  logic              r_cfo, w_cfo_n;
  logic              r_ssb, w_ssb_n;
  logic              r_sync, w_sync_n;
  logic              w_win, w_win_n, w_hit, w_miss, w_tmo;

  assign w_win = (r_cnt >= C_WLO);
  assign w_hit = N_id_2_valid_i && w_win &&
                 (N_id_2_i == r_req);
  // >= also catches a counter left saturated by WAIT_SSS
  assign w_miss = s_axis_in_tvalid &&
                  (r_cnt >= C_MISS) && !w_hit;
  assign w_tmo = (r_cnt >= C_TMO);
  assign w_hits_inc = r_hits + HW'(1);
  assign w_miss_inc = r_misses + MW'(1);

  // State and datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= S_SEARCH;
      r_cnt    <= '0;
      r_hits   <= '0;
      r_misses <= '0;
      r_req    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_hits   <= w_hits_n;
      r_misses <= w_misses_n;
      r_req    <= w_req_n;
    end
  end

  // Next state plus counter/latch updates
  always_comb begin
    w_state_n  = r_state;
    w_hits_n   = r_hits;
    w_misses_n = r_misses;
    w_req_n    = r_req;
    w_cnt_n    = r_cnt;
    if (s_axis_in_tvalid && (r_cnt < C_TMO))
      w_cnt_n = r_cnt + CNT_DW'(1);
    unique case (r_state)
      S_SEARCH: begin
        if (N_id_2_valid_i) begin
          w_req_n  = N_id_2_i;
          w_cnt_n  = '0;
          w_hits_n = HW'(1);
          w_state_n = (CONFIRM_HITS == 1) ?
                      S_WAIT : S_CONFIRM;
        end
      end
      S_CONFIRM: begin
        if (w_hit) begin
          w_hits_n = w_hits_inc;
          w_cnt_n  = '0;
          if (w_hits_inc >= C_HITS)
            w_state_n = S_WAIT;
        end else if (w_miss) begin
          w_hits_n  = '0;
          w_state_n = S_SEARCH;
        end
      end
      S_WAIT: begin
        if (w_hit)
          w_cnt_n = '0;
        if (N_id_valid_i) begin
          w_misses_n = '0;
          w_state_n  = S_TRACK;
        end else if (w_tmo) begin
          w_state_n = S_SEARCH;
        end
      end
      S_TRACK: begin
        if (w_hit) begin
          w_cnt_n    = '0;
          w_misses_n = '0;
        end else if (w_miss) begin
          w_misses_n = w_miss_inc;
          w_cnt_n    = C_WIN;
          if (w_miss_inc >= C_MAXM)
            w_state_n = S_SEARCH;
        end
      end
      default: w_state_n = S_SEARCH;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_win_n  = (w_cnt_n >= C_WLO);
    w_mode_n = 2'd0;
    if (w_state_n != S_SEARCH)
      w_mode_n = w_win_n ? 2'd1 : 2'd2;
    w_cfo_n = 1'b0;
    unique case (r_state)
      S_SEARCH: w_cfo_n = CFO_valid_i;
      S_TRACK:  w_cfo_n = CFO_valid_i && w_win;
      default:  w_cfo_n = 1'b0;
    endcase
    w_ssb_n  = (r_state == S_TRACK) && w_hit;
    w_sync_n = (w_state_n == S_TRACK);
  end

  // Output registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mode <= 2'd0;
      r_cfo  <= 1'b0;
      r_ssb  <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_mode <= w_mode_n;
      r_cfo  <= w_cfo_n;
      r_ssb  <= w_ssb_n;
      r_sync <= w_sync_n;
    end
  end

  assign PSS_detector_mode_o = r_mode;
  assign requested_N_id_2_o  = r_req;
  assign CFO_valid_o         = r_cfo;
  assign ssb_start_o         = r_ssb;
  assign synced_o            = r_sync;
  assign state_o             = r_state;
  assign miss_cnt_o          = r_misses;

endmodule
